// File: rtl/avl_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : avl_responder_pkg
// Brief   : Response codes, state encoding and helpers for avl_responder.
// Revision: 1.0 - initial release
// ============================================================================
package avl_responder_pkg;

  localparam logic [1:0] avl_okay   = 2'b00;
  localparam logic [1:0] avl_slverr = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE,
    ERR   = ST_ERR
  } state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/avl_responder.sv
`default_nettype none
// ============================================================================
// Module  : avl_responder
// Brief   : Avalon-MM agent bridging single writes and read bursts onto the
//           core valid/ready memory bus; illegal commands answer SLAVEERROR.
// Revision: 1.0 - initial release
// ============================================================================
module avl_responder
  import avl_responder_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_avl_address,
  input  logic [3:0]  s_avl_byteenable,
  input  logic        s_avl_lock,
  input  logic        s_avl_read,
  input  logic [31:0] s_avl_writedata,
  input  logic        s_avl_write,
  input  logic [2:0]  s_avl_burstcount,
  output logic [31:0] s_avl_readdata,
  output logic [1:0]  s_avl_response,
  output logic        s_avl_waitrequest,
  output logic        s_avl_readdatavalid,
  output logic        s_avl_writeresponsevalid,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] c_max_burst = 3'(MAX_BURST);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_count;
  logic [31:0] r_readdata;
  logic [1:0]  r_response;
  logic        r_rdvalid;
  logic        r_wrvalid;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        w_handshake;
  logic        w_unused_bits;

  assign w_unused_bits = ^{s_avl_lock, s_avl_address[1:0]};
  assign w_handshake   = r_mem_valid & mem_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (s_avl_write) begin
          w_state_next = (s_avl_burstcount == 3'd1 && s_avl_byteenable != 4'd0) ? WRITE : ERR;
        end else if (s_avl_read) begin
          w_state_next = (s_avl_burstcount != 3'd0 && s_avl_burstcount <= c_max_burst) ? READ : ERR;
        end
      end
      // mem_valid drops with the final handshake; leaving one cycle later
      // keeps waitrequest high through the last response pulse.
      READ, WRITE: begin
        if (!r_mem_valid) begin
          w_state_next = IDLE;
        end
      end
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= 3'd0;
      r_readdata  <= 32'd0;
      r_response  <= avl_okay;
      r_rdvalid   <= 1'b0;
      r_wrvalid   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
    end else begin
      r_rdvalid <= 1'b0;
      r_wrvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          case (w_state_next)
            WRITE: begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= word_addr(s_avl_address);
              r_mem_wdata <= s_avl_writedata;
              r_mem_wstrb <= s_avl_byteenable;
            end
            READ: begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= word_addr(s_avl_address);
              r_mem_wstrb <= 4'd0;
              r_count     <= s_avl_burstcount;
            end
            ERR: begin
              r_response <= avl_slverr;
              r_readdata <= 32'd0;
              if (s_avl_write) begin
                r_wrvalid <= 1'b1;
              end else begin
                r_rdvalid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        READ: begin
          if (w_handshake) begin
            r_rdvalid  <= 1'b1;
            r_readdata <= mem_rdata;
            r_response <= avl_okay;
            r_mem_addr <= r_mem_addr + 32'd4;
            r_count    <= r_count - 3'd1;
            if (r_count == 3'd1) begin
              r_mem_valid <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (w_handshake) begin
            r_wrvalid   <= 1'b1;
            r_response  <= avl_okay;
            r_mem_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_avl_waitrequest        = ~reset | (r_state != IDLE);
  assign s_avl_readdata           = r_readdata;
  assign s_avl_response           = r_response;
  assign s_avl_readdatavalid      = r_rdvalid;
  assign s_avl_writeresponsevalid = r_wrvalid;
  assign mem_valid                = r_mem_valid;
  assign mem_instr                = 1'b0;
  assign mem_addr                 = r_mem_addr;
  assign mem_wdata                = r_mem_wdata;
  assign mem_wstrb                = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_avl_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_avl_responder
// Brief   : Directed, table-driven bench for avl_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_avl_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_avl_address = '0;
  logic [3:0]  s_avl_byteenable = '0;
  logic        s_avl_lock = 1'b0;
  logic        s_avl_read = 1'b0;
  logic [31:0] s_avl_writedata = '0;
  logic        s_avl_write = 1'b0;
  logic [2:0]  s_avl_burstcount = '0;
  logic [31:0] s_avl_readdata;
  logic [1:0]  s_avl_response;
  logic        s_avl_waitrequest;
  logic        s_avl_readdatavalid;
  logic        s_avl_writeresponsevalid;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  avl_responder #(.MAX_BURST(4)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .s_avl_address            (s_avl_address),
    .s_avl_byteenable         (s_avl_byteenable),
    .s_avl_lock               (s_avl_lock),
    .s_avl_read               (s_avl_read),
    .s_avl_writedata          (s_avl_writedata),
    .s_avl_write              (s_avl_write),
    .s_avl_burstcount         (s_avl_burstcount),
    .s_avl_readdata           (s_avl_readdata),
    .s_avl_response           (s_avl_response),
    .s_avl_waitrequest        (s_avl_waitrequest),
    .s_avl_readdatavalid      (s_avl_readdatavalid),
    .s_avl_writeresponsevalid (s_avl_writeresponsevalid),
    .mem_valid                (mem_valid),
    .mem_instr                (mem_instr),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_wstrb                (mem_wstrb),
    .mem_rdata                (mem_rdata),
    .mem_ready                (mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  bc;
    int          dly;
    logic [31:0] rdata;
    int          hs;
    logic [31:0] maddr;
    logic [3:0]  wstrb;
    int          vcyc;
    int          rdv;
    int          wrv;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    int          wait_c;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  // memory model controls and bus monitor state
  int          mem_delay = 0;
  logic [31:0] rd_const = '0;
  logic        rd_addr_mode = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          m_wait, m_vcyc, m_hs, m_rdv, m_wrv, m_rdv_first, m_rdv_last;
  logic [31:0] m_addr0, m_wdata0, m_rdata;
  logic [3:0]  m_wstrb0;
  logic [1:0]  m_resp;
  logic [31:0] m_addrq[$];
  logic [31:0] m_rdataq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: timed out, got no event expected one", nm);
  endtask

  task automatic clear_mon();
    m_wait = 0; m_vcyc = 0; m_hs = 0; m_rdv = 0; m_wrv = 0;
    m_rdv_first = 0; m_rdv_last = 0;
    m_addr0 = '0; m_wdata0 = '0; m_rdata = '0; m_wstrb0 = '0; m_resp = '0;
    m_addrq.delete();
    m_rdataq.delete();
  endtask

  initial begin
    int vcnt;
    vcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!mem_valid) begin
        mem_ready = 1'b0;
        vcnt = 0;
      end else begin
        if (mem_ready) vcnt = 0;
        mem_ready = (vcnt >= mem_delay);
        vcnt++;
      end
      mem_rdata = rd_addr_mode ? {16'hA5A5, mem_addr[15:0]} : rd_const;
    end
  end

  initial begin
    clear_mon();
    forever begin
      @(posedge clock);
      cyc++;
      if (s_avl_waitrequest) m_wait++;
      if (mem_valid) m_vcyc++;
      if (mem_valid && mem_ready) begin
        if (m_hs == 0) begin
          m_addr0 = mem_addr; m_wstrb0 = mem_wstrb; m_wdata0 = mem_wdata;
        end
        m_addrq.push_back(mem_addr);
        m_hs++;
      end
      if (s_avl_readdatavalid) begin
        if (m_rdv == 0) m_rdv_first = cyc;
        m_rdv_last = cyc;
        m_rdv++;
        m_resp = s_avl_response;
        m_rdata = s_avl_readdata;
        m_rdataq.push_back(s_avl_readdata);
      end
      if (s_avl_writeresponsevalid) begin
        m_wrv++;
        m_resp = s_avl_response;
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [2:0] bc);
    int n;
    @(negedge clock);
    s_avl_read = rd; s_avl_write = wr; s_avl_address = a;
    s_avl_byteenable = be; s_avl_writedata = wd; s_avl_burstcount = bc;
    n = 0;
    while (s_avl_waitrequest && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) fail_now("accept");
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    s_avl_read = 1'b0; s_avl_write = 1'b0; s_avl_address = '0;
    s_avl_byteenable = '0; s_avl_writedata = '0; s_avl_burstcount = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (s_avl_waitrequest && n < 60);
    if (n >= 60) fail_now("idle");
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    clear_mon();
    mem_delay = v.dly;
    rd_const = v.rdata;
    rd_addr_mode = 1'b0;
    issue(v.rd, v.wr, v.addr, v.be, v.wdata, v.bc);
    wait_idle();
    chk({p, ".hs"}, 32'(m_hs), 32'(v.hs));
    if (v.hs > 0) begin
      chk({p, ".mem_addr"}, m_addr0, v.maddr);
      chk({p, ".mem_wstrb"}, 32'(m_wstrb0), 32'(v.wstrb));
      if (v.wr) chk({p, ".mem_wdata"}, m_wdata0, v.wdata);
    end
    chk({p, ".valid_cycles"}, 32'(m_vcyc), 32'(v.vcyc));
    chk({p, ".rdv_count"}, 32'(m_rdv), 32'(v.rdv));
    chk({p, ".wrv_count"}, 32'(m_wrv), 32'(v.wrv));
    chk({p, ".response"}, 32'(m_resp), 32'(v.resp));
    if (v.rdv > 0) chk({p, ".readdata"}, m_rdata, v.exp_rdata);
    chk({p, ".wait_cycles"}, 32'(m_wait), 32'(v.wait_c));
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] burst_addr[4];
    int n, seen;

    //        rd wr addr           be    wdata          bc  dly rdata          hs maddr          wstrb vcyc rdv wrv resp   exp_rdata      wait
    vecs[0] = '{1, 0, 32'h00000104, 4'h0, 32'h0,        3'd1, 1, 32'hDEADBEEF, 1, 32'h00000104, 4'h0, 2, 1, 0, 2'b00, 32'hDEADBEEF, 3};
    vecs[1] = '{0, 1, 32'h00000203, 4'h6, 32'h11223344, 3'd1, 3, 32'h0,        1, 32'h00000200, 4'h6, 4, 0, 1, 2'b00, 32'h0,        5};
    vecs[2] = '{1, 0, 32'h00000040, 4'h0, 32'h0,        3'd0, 0, 32'h12345678, 0, 32'h0,        4'h0, 0, 1, 0, 2'b10, 32'h0,        1};
    vecs[3] = '{0, 1, 32'h00000040, 4'hF, 32'h55555555, 3'd2, 0, 32'h0,        0, 32'h0,        4'h0, 0, 0, 1, 2'b10, 32'h0,        1};
    vecs[4] = '{0, 1, 32'h00000044, 4'h0, 32'h66666666, 3'd1, 0, 32'h0,        0, 32'h0,        4'h0, 0, 0, 1, 2'b10, 32'h0,        1};
    vecs[5] = '{1, 0, 32'h00000048, 4'h0, 32'h0,        3'd5, 0, 32'h77777777, 0, 32'h0,        4'h0, 0, 1, 0, 2'b10, 32'h0,        1};
    vecs[6] = '{1, 1, 32'h00000013, 4'hF, 32'hCAFEF00D, 3'd1, 0, 32'h99999999, 1, 32'h00000010, 4'hF, 1, 0, 1, 2'b00, 32'h0,        2};
    vecs[7] = '{1, 0, 32'h7FFFFFFF, 4'h0, 32'h0,        3'd1, 0, 32'h0BADF00D, 1, 32'h7FFFFFFC, 4'h0, 1, 1, 0, 2'b00, 32'h0BADF00D, 2};
    vecs[8] = '{1, 0, 32'h00000080, 4'h0, 32'h0,        3'd7, 0, 32'h88888888, 0, 32'h0,        4'h0, 0, 1, 0, 2'b10, 32'h0,        1};
    vecs[9] = '{1, 0, 32'h00000020, 4'h0, 32'h0,        3'd4, 1, 32'h55AA55AA, 4, 32'h00000020, 4'h0, 8, 4, 0, 2'b00, 32'h55AA55AA, 9};

    // reset state
    repeat (2) @(negedge clock);
    chk("rst.waitrequest", 32'(s_avl_waitrequest), 32'd1);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.rdvalid", 32'(s_avl_readdatavalid), 32'd0);
    chk("rst.wrvalid", 32'(s_avl_writeresponsevalid), 32'd0);
    chk("rst.mem_instr", 32'(mem_instr), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle.waitrequest", 32'(s_avl_waitrequest), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // burst across the top of the address space
    clear_mon();
    mem_delay = 0;
    rd_addr_mode = 1'b1;
    burst_addr[0] = 32'hFFFFFFF8; burst_addr[1] = 32'hFFFFFFFC;
    burst_addr[2] = 32'h00000000; burst_addr[3] = 32'h00000004;
    issue(1'b1, 1'b0, 32'hFFFFFFF8, 4'h0, 32'h0, 3'd4);
    chk("burst.mem_instr", 32'(mem_instr), 32'd0);
    wait_idle();
    chk("burst.hs", 32'(m_hs), 32'd4);
    chk("burst.rdv", 32'(m_rdv), 32'd4);
    chk("burst.latency", 32'(m_rdv_first - acc_cyc), 32'd2);
    chk("burst.back_to_back", 32'(m_rdv_last - m_rdv_first), 32'd3);
    chk("burst.wait_cycles", 32'(m_wait), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < m_addrq.size()) chk($sformatf("burst.addr%0d", i), m_addrq[i], burst_addr[i]);
      if (i < m_rdataq.size()) chk($sformatf("burst.rdata%0d", i), m_rdataq[i], {16'hA5A5, burst_addr[i][15:0]});
    end
    rd_addr_mode = 1'b0;

    // reset in the middle of a burst
    clear_mon();
    mem_delay = 0;
    issue(1'b1, 1'b0, 32'h00001000, 4'h0, 32'h0, 3'd4);
    n = 0; seen = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clock);
      if (s_avl_readdatavalid) seen++;
      n++;
    end
    if (seen < 2) fail_now("midburst.beats");
    #2;
    reset = 1'b0;
    #1;
    chk("arst.waitrequest", 32'(s_avl_waitrequest), 32'd1);
    chk("arst.mem_valid", 32'(mem_valid), 32'd0);
    chk("arst.rdvalid", 32'(s_avl_readdatavalid), 32'd0);
    chk("arst.mem_addr", mem_addr, 32'd0);
    chk("arst.readdata", s_avl_readdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_mon();
    repeat (10) @(negedge clock);
    chk("post_rst.rdv", 32'(m_rdv), 32'd0);
    chk("post_rst.hs", 32'(m_hs), 32'd0);
    chk("post_rst.waitrequest", 32'(s_avl_waitrequest), 32'd0);
    run_vec(vecs[7], 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
